elevator_request_scheduler: RTL and testbench

Collects floor requests from cabin and hall buttons, keeps them in a pending bitmap and picks the next floor with a SCAN (elevator) policy. It drives the floor request into `Elevator_System_Top`, waits for that block's `COMPLETE`, then retires the served floor. It sits directly upstream of the elevator system: `TARGET_FLOOR` feeds `REQUESTED_FLOOR`, and `OUT_CURRENT_FLOOR` feeds back into `CUR_FLOOR`.

---
 rtl/elevator_request_scheduler.sv | 164 ++++++++++++++++
 tb/tb_elevator_request_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_scheduler.sv
// SCAN-policy floor request scheduler: keeps a pending-request bitmap, dispatches one
// target floor at a time to the elevator system and retires it when the car reports arrival.
module elevator_request_scheduler #(
    parameter int NUM_FLOORS   = 16,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  REQ_VALID,
    input  logic [3:0]            REQ_FLOOR,
    input  logic [3:0]            CUR_FLOOR,
    input  logic                  COMPLETE,
    input  logic                  HOLD,
    output logic [3:0]            TARGET_FLOOR,
    output logic                  TARGET_VALID,
    output logic                  SCAN_UP,
    output logic [NUM_FLOORS-1:0] PENDING,
    output logic                  BUSY,
    output logic                  REQ_DROP
);

    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [4:0] FLOOR_LIMIT = 5'(NUM_FLOORS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SELECT   = 2'd1,
        DISPATCH = 2'd2,
        DWELL    = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [3:0]            target_reg, target_next;
    logic                  target_valid_reg, target_valid_next;
    logic                  scan_up_reg, scan_up_next;
    logic [NUM_FLOORS-1:0] pending_reg, pending_next;
    logic                  drop_reg, drop_next;
    logic [CW-1:0]         dwell_reg, dwell_next;

    logic                  retire;
    logic                  req_out_of_range;
    logic [NUM_FLOORS-1:0] req_hit;
    logic [NUM_FLOORS-1:0] retire_hit;
    logic [NUM_FLOORS-1:0] up_mask;
    logic [NUM_FLOORS-1:0] down_mask;
    logic [3:0]            up_idx;
    logic [3:0]            down_idx;

    assign retire = (state_reg == DISPATCH) && COMPLETE && (CUR_FLOOR == target_reg);
    assign req_out_of_range = REQ_VALID && ({1'b0, REQ_FLOOR} >= FLOOR_LIMIT);

    // Per-floor decode: request set, retire clear, and the two sweep-eligibility masks.
    // The floor equal to CUR_FLOOR appears in both masks.
    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            assign req_hit[gi]    = REQ_VALID && (REQ_FLOOR == 4'(gi));
            assign retire_hit[gi] = retire && (target_reg == 4'(gi));
            assign up_mask[gi]    = pending_reg[gi] && (4'(gi) >= CUR_FLOOR);
            assign down_mask[gi]  = pending_reg[gi] && (4'(gi) <= CUR_FLOOR);
        end
    endgenerate

    // Nearest eligible floor above (lowest set bit) and below (highest set bit).
    always_comb begin
        up_idx = 4'd0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (up_mask[i]) up_idx = 4'(i);
        end
    end

    always_comb begin
        down_idx = 4'd0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (down_mask[i]) down_idx = 4'(i);
        end
    end

    always_comb begin
        state_next        = state_reg;
        target_next       = target_reg;
        target_valid_next = target_valid_reg;
        scan_up_next      = scan_up_reg;
        dwell_next        = dwell_reg;
        // Clear is applied after set so a request for the retiring floor is absorbed.
        pending_next      = (pending_reg | req_hit) & ~retire_hit;
        drop_next         = req_out_of_range;

        case (state_reg)
            IDLE: begin
                if ((pending_reg != '0) && !HOLD) state_next = SELECT;
            end
            SELECT: begin
                if (pending_reg == '0) begin
                    state_next        = IDLE;
                    target_valid_next = 1'b0;
                end else begin
                    state_next        = DISPATCH;
                    target_valid_next = 1'b1;
                    if (scan_up_reg) begin
                        if (up_mask != '0) begin
                            target_next = up_idx;
                        end else begin
                            scan_up_next = 1'b0;
                            target_next  = down_idx;
                        end
                    end else begin
                        if (down_mask != '0) begin
                            target_next = down_idx;
                        end else begin
                            scan_up_next = 1'b1;
                            target_next  = up_idx;
                        end
                    end
                end
            end
            DISPATCH: begin
                if (retire) begin
                    target_valid_next = 1'b0;
                    dwell_next        = DWELL_LOAD;
                    state_next        = DWELL;
                end
            end
            DWELL: begin
                if (HOLD) begin
                    dwell_next = DWELL_LOAD;
                end else if (dwell_reg == '0) begin
                    state_next = SELECT;
                end else begin
                    dwell_next = dwell_reg - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            target_reg       <= 4'd0;
            target_valid_reg <= 1'b0;
            scan_up_reg      <= 1'b1;
            pending_reg      <= '0;
            drop_reg         <= 1'b0;
            dwell_reg        <= '0;
        end else begin
            state_reg        <= state_next;
            target_reg       <= target_next;
            target_valid_reg <= target_valid_next;
            scan_up_reg      <= scan_up_next;
            pending_reg      <= pending_next;
            drop_reg         <= drop_next;
            dwell_reg        <= dwell_next;
        end
    end

    assign TARGET_FLOOR = target_reg;
    assign TARGET_VALID = target_valid_reg;
    assign SCAN_UP      = scan_up_reg;
    assign PENDING      = pending_reg;
    assign BUSY         = (state_reg != IDLE);
    assign REQ_DROP     = drop_reg;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Bench for elevator_request_scheduler: directed scenarios with literal expectations plus
// a randomized run, all shadowed every cycle by a rule-level model of the scheduler.
module tb_elevator_request_scheduler;

    localparam int NF = 12;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [3:0]    req_floor = 4'd0;
    logic [3:0]    cur_floor = 4'd0;
    logic          complete = 1'b0;
    logic          hold = 1'b0;
    logic [3:0]    target_floor;
    logic          target_valid;
    logic          scan_up;
    logic [NF-1:0] pending;
    logic          busy;
    logic          req_drop;

    int checks = 0;
    int failures = 0;

    elevator_request_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(DW)) dut (
        .clk(clk), .rst(rst), .REQ_VALID(req_valid), .REQ_FLOOR(req_floor),
        .CUR_FLOOR(cur_floor), .COMPLETE(complete), .HOLD(hold),
        .TARGET_FLOOR(target_floor), .TARGET_VALID(target_valid), .SCAN_UP(scan_up),
        .PENDING(pending), .BUSY(busy), .REQ_DROP(req_drop)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 choosing, 2 car travelling, 3 resting at a floor.
    int       m_phase;
    int       m_target;
    bit       m_tv;
    bit       m_up;
    bit [15:0] m_pend;
    bit       m_drop;
    int       m_rest;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_target = 0; m_tv = 0; m_up = 1; m_pend = '0; m_drop = 0; m_rest = 0;
    endtask

    task automatic model_step();
        bit [15:0] np;
        int nphase, ntarget, nrest, above, below, cur;
        bit ntv, nup, ndrop;
        np = m_pend; nphase = m_phase; ntarget = m_target; ntv = m_tv; nup = m_up;
        nrest = m_rest; ndrop = 0;
        cur = int'(cur_floor);
        if (req_valid) begin
            if (int'(req_floor) < NF) np[req_floor] = 1'b1;
            else ndrop = 1'b1;
        end
        case (m_phase)
            0: if (m_pend != 0 && !hold) nphase = 1;
            1: begin
                if (m_pend == 0) begin
                    nphase = 0; ntv = 0;
                end else begin
                    above = -1; below = -1;
                    for (int f = cur; f < NF; f++) if (m_pend[f]) begin above = f; break; end
                    for (int f = (cur < NF ? cur : NF - 1); f >= 0; f--) if (m_pend[f]) begin below = f; break; end
                    if (m_up) begin
                        if (above >= 0) ntarget = above;
                        else begin nup = 0; ntarget = below; end
                    end else begin
                        if (below >= 0) ntarget = below;
                        else begin nup = 1; ntarget = above; end
                    end
                    ntv = 1; nphase = 2;
                end
            end
            2: if (complete && cur == m_target) begin
                np[m_target] = 1'b0; ntv = 0; nrest = DW - 1; nphase = 3;
            end
            default: begin
                if (hold) nrest = DW - 1;
                else if (m_rest == 0) nphase = 1;
                else nrest = m_rest - 1;
            end
        endcase
        m_pend = np; m_phase = nphase; m_target = ntarget; m_tv = ntv; m_up = nup;
        m_rest = nrest; m_drop = ndrop;
    endtask

    task automatic compare_all();
        chk("target_floor", int'(target_floor), m_target);
        chk("target_valid", int'(target_valid), int'(m_tv));
        chk("scan_up", int'(scan_up), int'(m_up));
        chk("pending", int'(pending), int'(m_pend[NF-1:0]));
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("req_drop", int'(req_drop), int'(m_drop));
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            model_step();
            #1 compare_all();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_target_floor"}, int'(target_floor), 0);
        chk({tag, "_target_valid"}, int'(target_valid), 0);
        chk({tag, "_scan_up"}, int'(scan_up), 1);
        chk({tag, "_pending"}, int'(pending), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_req_drop"}, int'(req_drop), 0);
    endtask

    task automatic wait_tv();
        bit ok = 0;
        for (int n = 0; n < 60; n++) begin
            if (target_valid) begin ok = 1; break; end
            tick();
        end
        chk("wait_target_valid", int'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 60; n++) begin
            if (!busy) begin ok = 1; break; end
            tick();
        end
        chk("wait_idle", int'(ok), 1);
    endtask

    task automatic request(input int f);
        req_valid = 1'b1; req_floor = 4'(f);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic arrive();
        cur_floor = target_floor; complete = 1'b1;
        tick();
        complete = 1'b0;
    endtask

    task automatic async_reset();
        #3 rst = 1'b1;
        model_reset();
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int order [4];
        int dirs [4];
        int exp_order [4];
        int exp_dirs [4];
        int cyc;
        exp_order = '{7, 9, 3, 1};
        exp_dirs  = '{1, 1, 0, 0};
        model_reset();

        #23 rst = 1'b0;
        tick();
        check_reset_values("reset");

        // Basic dispatch and busy drop after dwell
        cur_floor = 4'd0;
        request(2);
        chk("basic_pending_bit", int'(pending), 4);
        chk("basic_busy_e", int'(busy), 0);
        tick();
        chk("basic_busy_e1", int'(busy), 1);
        chk("basic_tv_e1", int'(target_valid), 0);
        tick();
        chk("basic_tv_e2", int'(target_valid), 1);
        chk("basic_tf_e2", int'(target_floor), 2);
        arrive();
        chk("basic_pending_cleared", int'(pending), 0);
        chk("basic_tv_cleared", int'(target_valid), 0);
        cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (!busy) begin cyc = n; break; end
        end
        chk("basic_busy_drop_cycles", cyc, DW + 1);

        // SCAN order from floor 5 with requests 1,7,3,9
        cur_floor = 4'd5; hold = 1'b1;
        request(1); request(7); request(3); request(9);
        hold = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_tv();
            order[k] = int'(target_floor);
            dirs[k]  = int'(scan_up);
            arrive();
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("scan_order_%0d", k), order[k], exp_order[k]);
            chk($sformatf("scan_dir_%0d", k), dirs[k], exp_dirs[k]);
        end
        wait_idle();

        // HOLD in dispatch leaves target; HOLD in dwell restarts full dwell
        request(6);
        wait_tv();
        chk("hold_tf_before", int'(target_floor), 6);
        hold = 1'b1;
        request(8);
        tick(); tick();
        chk("hold_dispatch_tf", int'(target_floor), 6);
        chk("hold_dispatch_tv", int'(target_valid), 1);
        hold = 1'b0;
        arrive();
        tick();
        hold = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        hold = 1'b0;
        cyc = 11;
        for (int n = 0; n < 30; n++) begin
            if (target_valid) break;
            tick();
            cyc++;
        end
        chk("hold_dwell_delay", cyc, 10 + 1 + DW + 1);
        chk("hold_next_tf", int'(target_floor), 8);

        // Request for the retiring floor is absorbed
        cur_floor = 4'd8; complete = 1'b1; req_valid = 1'b1; req_floor = 4'd8;
        tick();
        complete = 1'b0; req_valid = 1'b0;
        chk("collision_pending", int'(pending), 0);

        // Out-of-range request is dropped
        request(15);
        chk("drop_pulse", int'(req_drop), 1);
        chk("drop_pending", int'(pending), 0);
        tick();
        chk("drop_pulse_end", int'(req_drop), 0);
        wait_idle();

        // COMPLETE at a mismatched floor is ignored
        request(3);
        wait_tv();
        chk("mismatch_tf", int'(target_floor), 3);
        complete = 1'b1;
        tick();
        complete = 1'b0;
        chk("mismatch_tv", int'(target_valid), 1);
        chk("mismatch_pending", int'(pending), 8);
        arrive();
        wait_idle();

        // Request equal to the current floor
        request(3);
        tick(); tick();
        chk("same_floor_tv", int'(target_valid), 1);
        chk("same_floor_tf", int'(target_floor), 3);
        arrive();
        chk("same_floor_pending", int'(pending), 0);
        wait_idle();

        // Asynchronous reset mid-dispatch with three requests pending
        hold = 1'b1;
        request(2); request(5); request(10);
        hold = 1'b0;
        wait_tv();
        async_reset();
        for (int n = 0; n < 10; n++) tick();
        chk("post_reset_tv", int'(target_valid), 0);
        chk("post_reset_pending", int'(pending), 0);

        // Randomized traffic with an emulated car
        for (int n = 0; n < 3000; n++) begin
            complete  = 1'b0;
            req_valid = ($urandom_range(0, 3) == 0);
            req_floor = 4'($urandom_range(0, 15));
            hold      = ($urandom_range(0, 9) == 0);
            if (target_valid) begin
                if ($urandom_range(0, 4) == 0) begin
                    cur_floor = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : target_floor;
                    complete  = 1'b1;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                cur_floor = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 999) == 0) async_reset();
            else tick();
        end
        req_valid = 1'b0; complete = 1'b0; hold = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
